sbp_lookup_injector: RTL
========================

SBP_LOOKUP_INJECTOR -- requirements
Module: sbp_lookup_injector

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  STAGE_ID_BITS  6  width of stage_id.
  LOCATION_BITS  11  width of location.
  RESULT_BITS  24  width of result word, padded.
  CREDITS  16  tail result-buffer depth; maximum number of lookups in flight.
  UPD_STARVE_MAX  8  consecutive lost arbitrations after which a pending update wins.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-low reset.
  lkp_valid_i  in  1  lookup request valid.
  lkp_ready_o  out  1  lookup request accepted this cycle when high with lkp_valid_i.
  lkp_ip_addr_i  in  32  address to look up.
  upd_valid_i  in  1  update request valid.
  upd_ready_o  out  1  update accepted this cycle when high with upd_valid_i.
  upd_prefix_i  in  32  prefix to write.
  upd_prefix_len_i  in  6  prefix length, 0..32.
  upd_stage_id_i  in  STAGE_ID_BITS  target stage.
  upd_location_i  in  LOCATION_BITS  target location.
  upd_result_i  in  RESULT_BITS  memory result field.
  credit_return_i  in  1  tail consumed one lookup result.
  update_o  out  1  pipeline head: write beat.
  ip_addr_o  out  32  pipeline head: address or prefix.
  bit_pos_o  out  6  pipeline head: bit position or prefix length.
  stage_id_o  out  STAGE_ID_BITS  pipeline head: stage to visit.
  location_o  out  LOCATION_BITS  pipeline head: location to visit.
  result_o  out  RESULT_BITS  pipeline head: initial result or write data.
  valid_o  out  1  head beat carries a request.
  credit_cnt_o  out  $clog2(CREDITS+1)  available credits.
  credit_err_o  out  1  sticky: credit returned while credits were already full.

Function
REQ-003 The pipeline SHALL have no backpressure; the block SHALL present exactly one beat per clk, idle or request.
REQ-004 An idle beat SHALL drive valid_o=0, update_o=0, stage_id_o=0, and all other head outputs 0; stage ID 0 SHALL match no stage.
REQ-005 A lookup beat SHALL drive valid_o=1, update_o=0, ip_addr_o=lkp_ip_addr_i, bit_pos_o=0, stage_id_o=1, location_o=0, result_o=0.
REQ-006 An update beat SHALL drive valid_o=1, update_o=1, ip_addr_o=upd_prefix_i, bit_pos_o=upd_prefix_len_i, stage_id_o=upd_stage_id_i, location_o=upd_location_i, result_o=upd_result_i.
REQ-007 Head outputs SHALL be registered: a request accepted at edge N SHALL appear on the head for the cycle after edge N only; the next cycle's beat is idle unless another request is accepted.
REQ-008 Arbitration SHALL be combinational on current inputs and state; at most one request SHALL be accepted per cycle.
REQ-009 force_upd SHALL be (starve_cnt == UPD_STARVE_MAX).
REQ-010 lkp_ready_o SHALL be (credit_cnt != 0) and not (upd_valid_i and force_upd).
REQ-011 upd_ready_o SHALL be force_upd, or not lkp_valid_i, or (credit_cnt == 0).
REQ-012 If both requests are valid and both readies evaluate high, the lookup SHALL win and upd_ready_o SHALL be forced low.
REQ-013 Updates SHALL consume no credit.
REQ-014 starve_cnt SHALL increment, saturating at UPD_STARVE_MAX, each cycle upd_valid_i=1 and the update is not accepted.
REQ-015 starve_cnt SHALL clear to 0 when an update is accepted or when upd_valid_i=0.
REQ-016 credit_cnt SHALL decrement by 1 on lookup accept and increment by 1 on credit_return_i.
REQ-017 A simultaneous lookup accept and credit_return_i SHALL leave credit_cnt unchanged.
REQ-018 credit_return_i when credit_cnt==CREDITS, with no simultaneous accept, SHALL leave credit_cnt at CREDITS and set credit_err_o until reset.
REQ-019 Requests with an out-of-range upd_prefix_len_i (>32) SHALL still be accepted; they are forwarded unmodified.

Reset
REQ-020 When rst=0, asynchronously: every head output SHALL be 0 (idle beat), starve_cnt=0, credit_cnt=CREDITS, credit_err_o=0.
REQ-021 While rst=0, lkp_ready_o and upd_ready_o SHALL be 0, and no request SHALL be accepted.
REQ-022 A reset asserted mid-operation SHALL discard any beat in the head register; in-flight credits are not recovered other than by the reset value.
REQ-023 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-024 Single lookup 0xC0A80001 after reset -> next cycle: valid_o=1, update_o=0, stage_id_o=1, location_o=0, bit_pos_o=0, ip_addr_o=0xC0A80001; credit_cnt_o=15; the following cycle is an idle beat.
REQ-025 Update prefix 0x0A000000, len 8, stage 3, loc 5, result 0x031050 -> next cycle: update_o=1, bit_pos_o=8, stage_id_o=3, location_o=5, result_o=0x031050; credit_cnt_o=16.
REQ-026 17 back-to-back lookups, no credit returns -> 16 accepted; lkp_ready_o=0 with credit_cnt_o=0.
REQ-027 Then one credit_return_i -> exactly one further lookup accepted.
REQ-028 Lookups and an update both held valid continuously -> the update loses 8 cycles and is accepted on the 9th; starve_cnt returns to 0.
REQ-029 Lookup accept together with credit_return_i at credit_cnt=10 -> credit_cnt stays 10.
REQ-030 credit_return_i at credit_cnt=16 -> credit_err_o=1 and credit_cnt stays 16.
REQ-031 rst=0 pulse while a beat is on the head -> all head outputs 0, credit_cnt_o=16, credit_err_o=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sbp_lookup_injector.sv
// Injects lookup or update beats into a stage pipeline head; one registered beat per clk (1-cycle latency).
// No pipeline backpressure: lookups are throttled by tail credits, updates win after UPD_STARVE_MAX lost arbitrations.
module sbp_lookup_injector #(
  parameter int STAGE_ID_BITS  = 6,
  parameter int LOCATION_BITS  = 11,
  parameter int RESULT_BITS    = 24,
  parameter int CREDITS        = 16,
  parameter int UPD_STARVE_MAX = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             lkp_valid_i,
  output logic                             lkp_ready_o,
  input  logic [31:0]                      lkp_ip_addr_i,
  input  logic                             upd_valid_i,
  output logic                             upd_ready_o,
  input  logic [31:0]                      upd_prefix_i,
  input  logic [5:0]                       upd_prefix_len_i,
  input  logic [STAGE_ID_BITS-1:0]         upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0]         upd_location_i,
  input  logic [RESULT_BITS-1:0]           upd_result_i,
  input  logic                             credit_return_i,
  output logic                             update_o,
  output logic [31:0]                      ip_addr_o,
  output logic [5:0]                       bit_pos_o,
  output logic [STAGE_ID_BITS-1:0]         stage_id_o,
  output logic [LOCATION_BITS-1:0]         location_o,
  output logic [RESULT_BITS-1:0]           result_o,
  output logic                             valid_o,
  output logic [$clog2(CREDITS+1)-1:0]     credit_cnt_o,
  output logic                             credit_err_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int SW = $clog2(UPD_STARVE_MAX + 1);
  localparam logic [CW-1:0] CREDITS_FULL = CW'(CREDITS);
  localparam logic [SW-1:0] STARVE_MAX   = SW'(UPD_STARVE_MAX);

  typedef struct packed {
    logic                     valid;
    logic                     update;
    logic [31:0]              ip_addr;
    logic [5:0]               bit_pos;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } beat_t;

  logic [CW-1:0] credit_cnt;
  logic [SW-1:0] starve_cnt;
  logic          credit_err;
  logic          force_upd;
  logic          lkp_rdy;
  logic          upd_rdy;
  logic          lkp_acc;
  logic          upd_acc;
  beat_t         head;
  beat_t         head_nxt;

  assign force_upd = (starve_cnt == STARVE_MAX);

  // Readies are gated by rst so nothing is offered while reset is held.
  always_comb begin
    lkp_rdy = rst && (credit_cnt != '0) && !(upd_valid_i && force_upd);
    upd_rdy = rst && (force_upd || !lkp_valid_i || (credit_cnt == '0));
    if (lkp_valid_i && lkp_rdy) begin
      upd_rdy = 1'b0;
    end
  end

  assign lkp_ready_o = lkp_rdy;
  assign upd_ready_o = upd_rdy;
  assign lkp_acc     = lkp_valid_i && lkp_rdy;
  assign upd_acc     = upd_valid_i && upd_rdy;

  // Stage id 1 is the first pipeline stage; 0 is reserved for idle beats.
  always_comb begin
    head_nxt = '0;
    if (lkp_acc) begin
      head_nxt.valid    = 1'b1;
      head_nxt.ip_addr  = lkp_ip_addr_i;
      head_nxt.stage_id = STAGE_ID_BITS'(1);
    end else if (upd_acc) begin
      head_nxt.valid    = 1'b1;
      head_nxt.update   = 1'b1;
      head_nxt.ip_addr  = upd_prefix_i;
      head_nxt.bit_pos  = upd_prefix_len_i;
      head_nxt.stage_id = upd_stage_id_i;
      head_nxt.location = upd_location_i;
      head_nxt.result   = upd_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
    end else begin
      head <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!upd_valid_i || upd_acc) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A return while already full is dropped and flagged sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt <= CREDITS_FULL;
      credit_err <= 1'b0;
    end else begin
      case ({lkp_acc, credit_return_i})
        2'b10: credit_cnt <= credit_cnt - CW'(1);
        2'b01: begin
          if (credit_cnt == CREDITS_FULL) begin
            credit_err <= 1'b1;
          end else begin
            credit_cnt <= credit_cnt + CW'(1);
          end
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  assign valid_o      = head.valid;
  assign update_o     = head.update;
  assign ip_addr_o    = head.ip_addr;
  assign bit_pos_o    = head.bit_pos;
  assign stage_id_o   = head.stage_id;
  assign location_o   = head.location;
  assign result_o     = head.result;
  assign credit_cnt_o = credit_cnt;
  assign credit_err_o = credit_err;

endmodule
